// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and default sizes for the integer register file and its busy scoreboard.
package RegfilePkg;

   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;
   localparam int AW_DEF   = $clog2(NREG_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] reg_data_t;

   typedef struct packed {
      logic      en;
      reg_addr_t addr;
      reg_data_t data;
   } WritePort;

   // Snapshot of the whole data array, shared with the cosim checker.
   typedef reg_data_t RegPack [NREG_DEF];

endpackage

// File: rtl/regfile_scoreboard_write_arb.sv
// Resolves the NWR write ports into one write-enable and data word per register.
// The highest-index enabled port targeting a register wins; register 0 is never written.
module regfile_write_arb
   import RegfilePkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NWR  = 2,
   parameter int AW   = $clog2(NREG)
) (
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   output logic [NREG-1:0]     reg_we_o,
   output logic [XLEN-1:0]     reg_wdata_o [NREG]
);

   // Ascending port scan so a later (higher-priority) port overrides earlier matches.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         reg_we_o[r]    = 1'b0;
         reg_wdata_o[r] = '0;
      end
      for (int r = 1; r < NREG; r++) begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
               reg_we_o[r]    = 1'b1;
               reg_wdata_o[r] = wr_data_i[p*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_scoreboard
   import RegfilePkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2,
   parameter int NWR  = 2,
   parameter int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic [AW:0]         busy_cnt,
   output logic [NREG-1:0]     busy_vec
);

   localparam int CW = AW + 1;

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREG-1:0] reg_we;
   logic [XLEN-1:0] reg_wdata [NREG];

   regfile_write_arb #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
   ) u_arb (
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .reg_we_o    (reg_we),
      .reg_wdata_o (reg_wdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (reg_we[r]) regs_q[r] <= reg_wdata[r];
         end
      end
   end

   // A new reservation beats a writeback of the previous producer in the same cycle.
   always_comb begin
      busy_d    = busy_q;
      busy_d[0] = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         if (iss_en && (iss_addr == AW'(r))) busy_d[r] = 1'b1;
         else if (reg_we[r])                busy_d[r] = 1'b0;
      end
      cnt_d = CW'($countones(busy_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_vec = busy_q;
   assign busy_cnt = cnt_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            inRange;
      logic [XLEN-1:0] data;
      logic            busy;

      assign addr    = rd_addr[k*AW +: AW];
      assign inRange = (addr != '0) && (int'(addr) < NREG);

      always_comb begin
         data = '0;
         busy = 1'b0;
         if (!rst && inRange) begin
            data = regs_q[addr];
            busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (reg_we[addr]) begin
               data = reg_wdata[addr];
               busy = iss_en && (iss_addr == addr);
            end
`endif
         end
      end

      assign rd_data[k*XLEN +: XLEN] = data;
      assign rd_busy[k]              = busy;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_scoreboard;

   localparam int K_D0  = 0;
   localparam int K_D1  = 1;
   localparam int K_B0  = 2;
   localparam int K_CNT = 3;
   localparam int K_VEC = 4;

   logic         clk;
   logic         rst;
   logic [9:0]   rd_addr;
   logic [127:0] rd_data;
   logic [1:0]   rd_busy;
   logic [1:0]   wr_en;
   logic [9:0]   wr_addr;
   logic [127:0] wr_data;
   logic         iss_en;
   logic [4:0]   iss_addr;
   logic [5:0]   busy_cnt;
   logic [31:0]  busy_vec;

   typedef struct {
      int          kind;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t expQ[$];
   int   assertCount = 0;
   int   failCount   = 0;

   regfile_scoreboard #(
      .XLEN (64),
      .NREG (32),
      .NRD  (2),
      .NWR  (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy_cnt (busy_cnt),
      .busy_vec (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] we, input int wa0, input logic [63:0] wd0,
                                input int wa1, input logic [63:0] wd1,
                                input logic iss, input int ia, input int ra0, input int ra1);
      wr_en    = we;
      wr_addr  = {wa1[4:0], wa0[4:0]};
      wr_data  = {wd1, wd0};
      iss_en   = iss;
      iss_addr = ia[4:0];
      rd_addr  = {ra1[4:0], ra0[4:0]};
   endtask

   task automatic readOnly(input int ra0, input int ra1);
      applyStimulus(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, ra0, ra1);
   endtask

   task automatic checkOutput(input int kind, input logic [63:0] exp, input string name);
      exp_t e;
      e.kind = kind;
      e.exp  = exp;
      e.name = name;
      expQ.push_back(e);
   endtask

   // Monitor: compare every queued expectation against the outputs seen at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         while (expQ.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = expQ.pop_front();
            case (e.kind)
               K_D0:    act = rd_data[63:0];
               K_D1:    act = rd_data[127:64];
               K_B0:    act = {63'b0, rd_busy[0]};
               K_CNT:   act = {58'b0, busy_cnt};
               default: act = {32'b0, busy_vec};
            endcase
            assertCount++;
            if (act !== e.exp) begin
               failCount++;
               $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      readOnly(0, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput(K_CNT, 64'd0, "reset_cnt");
      checkOutput(K_VEC, 64'd0, "reset_vec");
      checkOutput(K_D0,  64'd0, "reset_data");
      checkOutput(K_B0,  64'd0, "reset_busy");
      tick();
      rst = 1'b0;
      tick();

      applyStimulus(2'b01, 0, 64'hFFFF, 0, 64'h0, 1'b1, 0, 0, 0);
      tick();
      readOnly(0, 0);
      checkOutput(K_D0,  64'd0, "x0_data");
      checkOutput(K_B0,  64'd0, "x0_busy");
      checkOutput(K_CNT, 64'd0, "x0_cnt");
      checkOutput(K_VEC, 64'd0, "x0_vec");
      tick();

      applyStimulus(2'b11, 3, 64'h11, 3, 64'h22, 1'b0, 0, 3, 3);
      tick();
      readOnly(3, 3);
      checkOutput(K_D0,  64'h22, "collide_port0");
      checkOutput(K_D1,  64'h22, "collide_port1");
      checkOutput(K_VEC, 64'd0,  "collide_notbusy");
      tick();

      applyStimulus(2'b00, 0, 64'h0, 0, 64'h0, 1'b1, 7, 7, 0);
      tick();
      readOnly(7, 0);
      checkOutput(K_B0,  64'd1,    "issue_busy");
      checkOutput(K_CNT, 64'd1,    "issue_cnt");
      checkOutput(K_VEC, 64'h80,   "issue_vec");
      tick();

      applyStimulus(2'b01, 7, 64'h42, 0, 64'h0, 1'b0, 0, 7, 0);
      tick();
      readOnly(7, 0);
      checkOutput(K_B0,  64'd0,  "wb_busy");
      checkOutput(K_D0,  64'h42, "wb_data");
      checkOutput(K_CNT, 64'd0,  "wb_cnt");
      tick();

      applyStimulus(2'b01, 7, 64'h55, 0, 64'h0, 1'b1, 7, 7, 0);
      tick();
      readOnly(7, 0);
      checkOutput(K_B0,  64'd1,  "setclr_busy");
      checkOutput(K_D0,  64'h55, "setclr_data");
      checkOutput(K_CNT, 64'd1,  "setclr_cnt");
      tick();

      applyStimulus(2'b10, 0, 64'h0, 7, 64'h66, 1'b0, 0, 7, 0);
      tick();
      readOnly(7, 0);
      checkOutput(K_B0,  64'd0,  "wb1_busy");
      checkOutput(K_D0,  64'h66, "wb1_data");
      checkOutput(K_CNT, 64'd0,  "wb1_cnt");
      tick();

      applyStimulus(2'b01, 9, 64'h111, 0, 64'h0, 1'b0, 0, 0, 0);
      tick();
      applyStimulus(2'b00, 0, 64'h0, 0, 64'h0, 1'b1, 9, 0, 0);
      tick();
      applyStimulus(2'b01, 9, 64'hABC, 0, 64'h0, 1'b0, 0, 9, 0);
`ifdef REGFILE_BYPASS_EN
      checkOutput(K_D0, 64'hABC, "bypass_data");
      checkOutput(K_B0, 64'd0,   "bypass_busy");
`else
      checkOutput(K_D0, 64'h111, "nobypass_data");
      checkOutput(K_B0, 64'd1,   "nobypass_busy");
`endif
      tick();
      readOnly(9, 0);
      checkOutput(K_D0,  64'hABC, "after_wb_data");
      checkOutput(K_B0,  64'd0,   "after_wb_busy");
      checkOutput(K_CNT, 64'd0,   "after_wb_cnt");
      tick();

      applyStimulus(2'b01, 9, 64'hBBB, 0, 64'h0, 1'b1, 9, 9, 0);
`ifdef REGFILE_BYPASS_EN
      checkOutput(K_D0, 64'hBBB, "bypass_iss_data");
      checkOutput(K_B0, 64'd1,   "bypass_iss_busy");
`else
      checkOutput(K_D0, 64'hABC, "nobypass_iss_data");
      checkOutput(K_B0, 64'd0,   "nobypass_iss_busy");
`endif
      tick();
      readOnly(9, 0);
      checkOutput(K_D0,  64'hBBB, "reissue_data");
      checkOutput(K_B0,  64'd1,   "reissue_busy");
      checkOutput(K_CNT, 64'd1,   "reissue_cnt");
      tick();
      applyStimulus(2'b01, 9, 64'hCCC, 0, 64'h0, 1'b0, 0, 9, 0);
      tick();
      readOnly(9, 0);
      checkOutput(K_B0,  64'd0, "reclear_busy");
      checkOutput(K_CNT, 64'd0, "reclear_cnt");
      tick();

      for (int i = 1; i < 32; i++) begin
         applyStimulus(2'b00, 0, 64'h0, 0, 64'h0, 1'b1, i, 0, 0);
         tick();
      end
      readOnly(31, 0);
      checkOutput(K_CNT, 64'd31,         "sat_cnt");
      checkOutput(K_VEC, 64'hFFFF_FFFE,  "sat_vec");
      checkOutput(K_B0,  64'd1,          "sat_busy31");
      tick();

      for (int i = 1; i < 32; i += 2) begin
         applyStimulus((i < 31) ? 2'b11 : 2'b01, i, 64'(i * 16), i + 1, 64'((i + 1) * 16),
                       1'b0, 0, 0, 0);
         tick();
         if (i == 1) checkOutput(K_CNT, 64'd29, "drain_first_pair_cnt");
      end
      readOnly(31, 30);
      checkOutput(K_CNT, 64'd0,     "drain_cnt");
      checkOutput(K_VEC, 64'd0,     "drain_vec");
      checkOutput(K_D0,  64'h1F0,   "drain_x31");
      checkOutput(K_D1,  64'h1E0,   "drain_x30");
      checkOutput(K_B0,  64'd0,     "drain_busy31");
      tick();

      applyStimulus(2'b01, 5, 64'hDEAD, 0, 64'h0, 1'b1, 6, 5, 0);
      tick();
      readOnly(5, 6);
      checkOutput(K_D0,  64'hDEAD, "pre_rst_data");
      checkOutput(K_CNT, 64'd1,    "pre_rst_cnt");
      tick();
      #2;
      rst = 1'b1;
      checkOutput(K_D0,  64'd0, "midrst_data");
      checkOutput(K_CNT, 64'd0, "midrst_cnt");
      checkOutput(K_VEC, 64'd0, "midrst_vec");
      tick();
      rst = 1'b0;
      tick();
      readOnly(6, 5);
      checkOutput(K_B0, 64'd0, "post_rst_lost_reservation");
      checkOutput(K_D1, 64'd0, "post_rst_x5");
      tick();

      for (int n = 0; n < 10 && expQ.size() > 0; n++) @(posedge clk);
      if (expQ.size() > 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain: got %0d pending, expected 0 pending", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-port integer register file for the pipelined CPU core.
- Provides NRD combinational read ports and NWR synchronous write ports.
- Holds a per-register busy scoreboard, set when an instruction issues with a destination and cleared at writeback. Issue logic uses it for RAW hazard detection.
- Provides a busy-count output and an optional same-cycle write-to-read bypass.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers. Register 0 is hardwired to zero.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports. Port index NWR-1 has the highest priority.
- AW, $clog2(NREG), address width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NRD*AW  read addresses.
- rd_data  out  NRD*XLEN  read data.
- rd_busy  out  NRD  busy flag of each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue strobe: reserve a destination register.
- iss_addr  in  AW  destination register to mark busy.
- busy_cnt  out  $clog2(NREG)+1  number of registers currently busy.
- busy_vec  out  NREG  raw scoreboard, bit i = register i busy.

Behaviour:
- Reset:
  - All registers go to 0, all busy bits to 0, busy_cnt to 0.
  - Asynchronous: applies immediately, mid-operation included. Pending reservations are lost.
  - rd_data reads 0 and rd_busy reads 0 while rst is high.
- Reads:
  - Combinational, zero latency.
  - Address 0 always returns rd_data=0 and rd_busy=0.
  - Any address >= NREG (when NREG is not a power of 2) returns 0 and not busy.
- Writes:
  - Take effect on the posedge clk, so the written value is visible to reads in the following cycle.
  - Writes to address 0 are dropped.
  - If several write ports target the same address in one cycle, the highest-index enabled port wins. No error is flagged.
- Scoreboard, per register r != 0, at each posedge:
  - If iss_en and iss_addr==r, busy[r] <= 1.
  - Else if any wr_en targets r, busy[r] <= 0.
  - Otherwise busy[r] holds.
  - Set wins over clear in the same cycle: a new producer reserves the register while the old producer writes back.
  - iss_en with iss_addr==0 is ignored.
  - iss_en to an already-busy register keeps it busy (WAW allowed; no counting).
  - A writeback to a non-busy register writes data and leaves busy at 0.
- busy_cnt:
  - Registered.
  - Equals the popcount of busy_vec, updated in the same edge as busy_vec (computed from next-state busy bits).
  - Range 0..NREG-1.
- No handshake/backpressure: the block always accepts writes and issues. Stalling is the issue stage's decision based on rd_busy.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If a write port is enabled to rd_addr[k] (nonzero) in the current cycle, rd_data[k] returns that port's wr_data combinationally. Highest-index write port wins.
  - rd_busy[k] reads 0 in that cycle, unless iss_en targets the same address in that cycle.
- Undefined:
  - rd_data returns the stored (old) value.
  - rd_busy reflects the registered busy bit only.
  - A consumer therefore sees the new value and the cleared busy bit one cycle after writeback.

Decomposition:
- Package RegfilePkg holds:
  - Localparams XLEN_DEF and NREG_DEF.
  - Typedefs reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [XLEN-1:0]).
  - Struct WritePort {en, addr, data}.
  - The existing cosim RegPack type is reused for verification snapshots of the data array.
- One sub-module, regfile_write_arb: per-register priority resolve across the NWR write ports, producing a write-enable and data per register. Used both by the array and by the bypass mux.

Test Plan:
- Reset: write x5=0xDEAD, then assert rst mid-cycle → rd_data(x5)=0 immediately; busy_vec=0, busy_cnt=0.
- x0: wr_en to x0 with 0xFFFF, iss_en iss_addr=0 → rd_data(x0)=0, rd_busy=0, busy_cnt=0.
- Write collision: port0 writes x3=0x11 and port1 writes x3=0x22 in the same cycle → next cycle rd_data(x3)=0x22.
- Scoreboard:
  - Issue x7 → next cycle rd_busy(x7)=1, busy_cnt=1.
  - Writeback x7=0x42 → next cycle busy=0, data=0x42.
  - Issue x7 and writeback x7 in the same cycle → busy stays 1, data updated.
- Bypass (macro defined): write x9=0xABC while reading x9 in the same cycle → rd_data=0xABC, rd_busy=0. Without the macro → old value, and busy stays at its registered value.
- busy_cnt saturation: issue x1..x31 on consecutive cycles → busy_cnt=31; writeback all → busy_cnt returns to 0.
